// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D-cache memory-port arbiter: FSM states, requester IDs
// and the read-return tag carried through the tag pipe.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef struct packed {
        logic valid;
        logic owner;
    } tag_t;

    function automatic state_e grant_of(logic who);
        return (who == REQ_D) ? GNT_D : GNT_I;
    endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// RD_LAT-deep shift register of read tags; the output lines up with the memory's
// read data for the rd_mem cycle that pushed the tag.
module rd_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] tag_i,
    output logic [1:0] tag_o
);

    tag_t tag_q [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < RD_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0] <= tag_t'(tag_i);
            for (int k = 1; k < RD_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign tag_o = tag_q[RD_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (I-cache / D-cache) arbiter for the shared memory port, with read
// tagging and a drain window. Define ARB_RR_EN for round-robin ties; else D wins.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              req_d,
    input  logic              Rd_i,
    input  logic              Wr_i,
    input  logic              Rd_d,
    input  logic              Wr_d,
    input  logic [ADDR_W-1:0] Addr_i,
    input  logic [ADDR_W-1:0] Addr_d,
    input  logic [DATA_W-1:0] DataIn_i,
    input  logic [DATA_W-1:0] DataIn_d,
    output logic              gnt_i,
    output logic              gnt_d,
    output logic [ADDR_W-1:0] Addr_mem,
    output logic [DATA_W-1:0] DataIn_mem,
    output logic              rd_mem,
    output logic              wr_mem,
    input  logic [DATA_W-1:0] DataOut_mem,
    output logic [DATA_W-1:0] DataOut,
    output logic              rvalid_i,
    output logic              rvalid_d,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tie_pick;
    state_e           arb_state;

`ifdef ARB_RR_EN
    logic last_q, last_d;
    assign tie_pick = (last_q == REQ_I) ? REQ_D : REQ_I;
`else
    assign tie_pick = REQ_D;
`endif

    always_comb begin
        arb_state = IDLE;
        if (req_i && req_d) arb_state = grant_of(tie_pick);
        else if (req_d)     arb_state = GNT_D;
        else if (req_i)     arb_state = GNT_I;
    end

    // Owner-side view of the request/strobe inputs while a grant is held.
    logic              own_is_d, own_req, own_rd, own_wr, nogrant_err;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_data;

    assign own_is_d    = (state_q == GNT_D);
    assign own_req     = own_is_d ? req_d    : req_i;
    assign own_rd      = own_is_d ? Rd_d     : Rd_i;
    assign own_wr      = own_is_d ? Wr_d     : Wr_i;
    assign own_addr    = own_is_d ? Addr_d   : Addr_i;
    assign own_data    = own_is_d ? DataIn_d : DataIn_i;
    assign nogrant_err = ((Rd_i | Wr_i) & ~req_i) | ((Rd_d | Wr_d) & ~req_d);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_mem     = 1'b0;
        wr_mem     = 1'b0;
        Addr_mem   = '0;
        DataIn_mem = '0;
        err        = 1'b0;
        case (state_q)
            IDLE: begin
                err     = nogrant_err;
                state_d = arb_state;
            end
            GNT_I, GNT_D: begin
                if (!own_req) begin
                    state_d = DRAIN;
                    cnt_d   = CNT_W'(RD_LAT - 1);
                end else if (own_rd && own_wr) begin
                    err = 1'b1;
                end else begin
                    rd_mem     = own_rd;
                    wr_mem     = own_wr;
                    Addr_mem   = own_addr;
                    DataIn_mem = own_data;
                end
            end
            DRAIN: begin
                err = nogrant_err;
                if (cnt_q == '0) state_d = arb_state;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ARB_RR_EN
    always_comb begin
        last_d = last_q;
        if (state_d == GNT_D)      last_d = REQ_D;
        else if (state_d == GNT_I) last_d = REQ_I;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
`ifdef ARB_RR_EN
            last_q  <= REQ_I;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    tag_t tag_in, tag_out;
    assign tag_in.valid = rd_mem;
    assign tag_in.owner = own_is_d ? REQ_D : REQ_I;

    rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    assign rvalid_i = tag_out.valid && (tag_out.owner == REQ_I);
    assign rvalid_d = tag_out.valid && (tag_out.owner == REQ_D);
    assign gnt_i    = (state_q == GNT_I);
    assign gnt_d    = (state_q == GNT_D);
    assign busy     = (state_q != IDLE);
    assign DataOut  = DataOut_mem;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (RD_LAT=2): a D-cache burst table plus
// hand-written sequences for ties, drain, error, reset and non-owner strobes.
module tb_mem_arbiter;

    typedef struct packed {
        logic        rst, req_i, req_d, rd_i, wr_i, rd_d, wr_d;
        logic [15:0] addr_i, addr_d, din_i, din_d, dout;
    } in_t;

    typedef struct packed {
        logic        gnt_i, gnt_d, rd_mem, wr_mem;
        logic [15:0] addr, din, dout;
        logic        rv_i, rv_d, busy, err;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

`ifdef ARB_RR_EN
    localparam int RR = 1;
`else
    localparam int RR = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    in_t vin = '0;
    logic        gnt_i, gnt_d, rd_mem, wr_mem, rvalid_i, rvalid_d, busy, err;
    logic [15:0] Addr_mem, DataIn_mem, DataOut;
    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(2)) dut (
        .clk         (clk),
        .rst         (vin.rst),
        .req_i       (vin.req_i),
        .req_d       (vin.req_d),
        .Rd_i        (vin.rd_i),
        .Wr_i        (vin.wr_i),
        .Rd_d        (vin.rd_d),
        .Wr_d        (vin.wr_d),
        .Addr_i      (vin.addr_i),
        .Addr_d      (vin.addr_d),
        .DataIn_i    (vin.din_i),
        .DataIn_d    (vin.din_d),
        .gnt_i       (gnt_i),
        .gnt_d       (gnt_d),
        .Addr_mem    (Addr_mem),
        .DataIn_mem  (DataIn_mem),
        .rd_mem      (rd_mem),
        .wr_mem      (wr_mem),
        .DataOut_mem (vin.dout),
        .DataOut     (DataOut),
        .rvalid_i    (rvalid_i),
        .rvalid_d    (rvalid_d),
        .busy        (busy),
        .err         (err)
    );

    // mi(rst, req_i, req_d, Rd_i, Wr_i, Rd_d, Wr_d, Addr_i, Addr_d, DataIn_i, DataIn_d, DataOut_mem)
    function automatic in_t mi(int rs, int qi, int qd, int ri, int wi, int rd, int wd,
                               int ai, int ad, int di, int dd, int dm);
        in_t v;
        v.rst = 1'(rs); v.req_i = 1'(qi); v.req_d = 1'(qd);
        v.rd_i = 1'(ri); v.wr_i = 1'(wi); v.rd_d = 1'(rd); v.wr_d = 1'(wd);
        v.addr_i = 16'(ai); v.addr_d = 16'(ad); v.din_i = 16'(di); v.din_d = 16'(dd);
        v.dout = 16'(dm);
        return v;
    endfunction

    // mo(gnt_i, gnt_d, rd_mem, wr_mem, Addr_mem, DataIn_mem, DataOut, rvalid_i, rvalid_d, busy, err)
    function automatic out_t mo(int gi, int gd, int rm, int wm, int a, int d, int dm,
                                int vi, int vd, int b, int e);
        out_t v;
        v.gnt_i = 1'(gi); v.gnt_d = 1'(gd); v.rd_mem = 1'(rm); v.wr_mem = 1'(wm);
        v.addr = 16'(a); v.din = 16'(d); v.dout = 16'(dm);
        v.rv_i = 1'(vi); v.rv_d = 1'(vd); v.busy = 1'(b); v.err = 1'(e);
        return v;
    endfunction

    task automatic cyc(input string nm, input in_t v, input out_t e);
        out_t a;
        vin = v;
        #1;
        a.gnt_i = gnt_i; a.gnt_d = gnt_d; a.rd_mem = rd_mem; a.wr_mem = wr_mem;
        a.addr = Addr_mem; a.din = DataIn_mem; a.dout = DataOut;
        a.rv_i = rvalid_i; a.rv_d = rvalid_d; a.busy = busy; a.err = err;
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h (gi gd rd wr addr din dout rvi rvd busy err)", nm, a, e);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        vin = '0;
        vin.rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vin.rst = 1'b0;
    endtask

    vec_t tbl[15];

    initial begin
        // D-cache burst: 4 writes then 4 reads at 0x1230..0x1236, then release.
        tbl[0]  = '{mi(0,0,0,0,0,0,0, 0,0,      0,0,      'hD000), mo(0,0,0,0,0,      0,      'hD000,0,0,0,0)};
        tbl[1]  = '{mi(0,0,1,0,0,0,0, 0,'h1230, 0,0,      'hD001), mo(0,0,0,0,0,      0,      'hD001,0,0,0,0)};
        tbl[2]  = '{mi(0,0,1,0,0,0,1, 0,'h1230, 0,'hA000, 'hD002), mo(0,1,0,1,'h1230,'hA000,'hD002,0,0,1,0)};
        tbl[3]  = '{mi(0,0,1,0,0,0,1, 0,'h1232, 0,'hA001, 'hD003), mo(0,1,0,1,'h1232,'hA001,'hD003,0,0,1,0)};
        tbl[4]  = '{mi(0,0,1,0,0,0,1, 0,'h1234, 0,'hA002, 'hD004), mo(0,1,0,1,'h1234,'hA002,'hD004,0,0,1,0)};
        tbl[5]  = '{mi(0,0,1,0,0,0,1, 0,'h1236, 0,'hA003, 'hD005), mo(0,1,0,1,'h1236,'hA003,'hD005,0,0,1,0)};
        tbl[6]  = '{mi(0,0,1,0,0,1,0, 0,'h1230, 0,0,      'hD006), mo(0,1,1,0,'h1230,0,      'hD006,0,0,1,0)};
        tbl[7]  = '{mi(0,0,1,0,0,1,0, 0,'h1232, 0,0,      'hD007), mo(0,1,1,0,'h1232,0,      'hD007,0,0,1,0)};
        tbl[8]  = '{mi(0,0,1,0,0,1,0, 0,'h1234, 0,0,      'hD008), mo(0,1,1,0,'h1234,0,      'hD008,0,1,1,0)};
        tbl[9]  = '{mi(0,0,1,0,0,1,0, 0,'h1236, 0,0,      'hD009), mo(0,1,1,0,'h1236,0,      'hD009,0,1,1,0)};
        tbl[10] = '{mi(0,0,1,0,0,0,0, 0,'h1236, 0,0,      'hD00A), mo(0,1,0,0,'h1236,0,      'hD00A,0,1,1,0)};
        tbl[11] = '{mi(0,0,0,0,0,0,0, 0,'h1236, 0,0,      'hD00B), mo(0,1,0,0,0,      0,      'hD00B,0,1,1,0)};
        tbl[12] = '{mi(0,0,0,0,0,0,0, 0,0,      0,0,      'hD00C), mo(0,0,0,0,0,      0,      'hD00C,0,0,1,0)};
        tbl[13] = '{mi(0,0,0,0,0,0,0, 0,0,      0,0,      'hD00D), mo(0,0,0,0,0,      0,      'hD00D,0,0,1,0)};
        tbl[14] = '{mi(0,0,0,0,0,0,0, 0,0,      0,0,      'hD00E), mo(0,0,0,0,0,      0,      'hD00E,0,0,0,0)};

        @(negedge clk);
        do_reset();
        for (int k = 0; k < 15; k++) begin
            cyc($sformatf("burst_row%0d", k), tbl[k].i, tbl[k].o);
        end

        // Simultaneous requests twice; second grant waits out the drain.
        do_reset();
        cyc("tie1_idle",   mi(0,1,1,0,0,0,0, 0,0,0,0,'h11), mo(0,0,0,0,0,0,'h11,0,0,0,0));
        cyc("tie1_gnt",    mi(0,1,1,0,0,0,0, 0,0,0,0,'h12), mo(0,1,0,0,0,0,'h12,0,0,1,0));
        cyc("tie1_drop",   mi(0,1,0,0,0,0,0, 0,0,0,0,'h13), mo(0,1,0,0,0,0,'h13,0,0,1,0));
        cyc("tie2_drain0", mi(0,1,1,0,0,0,0, 0,0,0,0,'h14), mo(0,0,0,0,0,0,'h14,0,0,1,0));
        cyc("tie2_drain1", mi(0,1,1,0,0,0,0, 0,0,0,0,'h15), mo(0,0,0,0,0,0,'h15,0,0,1,0));
        cyc("tie2_gnt",    mi(0,1,1,0,0,0,0, 0,0,0,0,'h16), mo(RR,1-RR,0,0,0,0,'h16,0,0,1,0));

        // D drops right after its last read; I is waiting.
        do_reset();
        cyc("drn_idle",  mi(0,1,1,0,0,0,0, 'h4000,'h2000,0,0,'h21), mo(0,0,0,0,0,0,'h21,0,0,0,0));
        do_reset();
        cyc("drn_req",   mi(0,0,1,0,0,0,0, 'h4000,'h2000,0,0,'h22), mo(0,0,0,0,0,0,'h22,0,0,0,0));
        cyc("drn_rd0",   mi(0,1,1,0,0,1,0, 'h4000,'h2000,0,0,'h23), mo(0,1,1,0,'h2000,0,'h23,0,0,1,0));
        cyc("drn_rd1",   mi(0,1,1,0,0,1,0, 'h4000,'h2002,0,0,'h24), mo(0,1,1,0,'h2002,0,'h24,0,0,1,0));
        cyc("drn_drop",  mi(0,1,0,0,0,0,0, 'h4000,'h2002,0,0,'h25), mo(0,1,0,0,0,0,'h25,0,1,1,0));
        cyc("drn_c0",    mi(0,1,0,0,0,0,0, 'h4000,0,0,0,'h26),      mo(0,0,0,0,0,0,'h26,0,1,1,0));
        cyc("drn_c1",    mi(0,1,0,0,0,0,0, 'h4000,0,0,0,'h27),      mo(0,0,0,0,0,0,'h27,0,0,1,0));
        cyc("drn_gnt_i", mi(0,1,0,0,0,0,0, 'h4000,0,0,0,'h28),      mo(1,0,0,0,'h4000,0,'h28,0,0,1,0));

        // Stray strobe while idle, then owner Rd+Wr collision.
        do_reset();
        cyc("err_idle",  mi(0,0,1,0,1,0,0, 0,'h0040,0,0,'h31),      mo(0,0,0,0,0,0,'h31,0,0,0,1));
        cyc("err_rdwr",  mi(0,0,1,0,0,1,1, 0,'h0040,0,'h1234,'h32), mo(0,1,0,0,0,0,'h32,0,0,1,1));
        cyc("err_keep",  mi(0,0,1,0,0,1,0, 0,'h0040,0,0,'h33),      mo(0,1,1,0,'h0040,0,'h33,0,0,1,0));
        cyc("err_norv",  mi(0,0,1,0,0,0,0, 0,'h0040,0,0,'h34),      mo(0,1,0,0,'h0040,0,'h34,0,0,1,0));
        cyc("err_rv",    mi(0,0,1,0,0,0,0, 0,'h0040,0,0,'h35),      mo(0,1,0,0,'h0040,0,'h35,0,1,1,0));

        // Reset with two reads still in flight.
        do_reset();
        cyc("rst_req",   mi(0,0,1,0,0,0,0, 0,'h3000,0,0,'h41), mo(0,0,0,0,0,0,'h41,0,0,0,0));
        cyc("rst_rd0",   mi(0,0,1,0,0,1,0, 0,'h3000,0,0,'h42), mo(0,1,1,0,'h3000,0,'h42,0,0,1,0));
        cyc("rst_rd1",   mi(0,0,1,0,0,1,0, 0,'h3002,0,0,'h43), mo(0,1,1,0,'h3002,0,'h43,0,0,1,0));
        cyc("rst_hit",   mi(1,0,1,0,0,1,0, 0,'h3004,0,0,'h44), mo(0,1,1,0,'h3004,0,'h44,0,1,1,0));
        cyc("rst_after0",mi(0,0,0,0,0,0,0, 0,0,0,0,'h45),      mo(0,0,0,0,0,0,'h45,0,0,0,0));
        cyc("rst_after1",mi(0,0,0,0,0,0,0, 0,0,0,0,'h46),      mo(0,0,0,0,0,0,'h46,0,0,0,0));
        cyc("rst_after2",mi(0,0,0,0,0,0,0, 0,0,0,0,'h47),      mo(0,0,0,0,0,0,'h47,0,0,0,0));

        // Non-owner strobes during a D grant are ignored.
        do_reset();
        cyc("no_idle",   mi(0,1,1,0,0,0,0, 'h5555,'h1111,'h7777,'h2222,'h51), mo(0,0,0,0,0,0,'h51,0,0,0,0));
        cyc("no_wri",    mi(0,1,1,0,1,0,0, 'h5555,'h1111,'h7777,'h2222,'h52), mo(0,1,0,0,'h1111,'h2222,'h52,0,0,1,0));
        cyc("no_wrboth", mi(0,1,1,0,1,0,1, 'h5555,'h1112,'h7777,'hBEEF,'h53), mo(0,1,0,1,'h1112,'hBEEF,'h53,0,0,1,0));
        cyc("no_rdi",    mi(0,1,1,1,0,0,0, 'h5555,'h1112,'h7777,0,'h54),      mo(0,1,0,0,'h1112,0,'h54,0,0,1,0));
        cyc("no_rv0",    mi(0,1,1,0,0,0,0, 'h5555,'h1112,'h7777,0,'h55),      mo(0,1,0,0,'h1112,0,'h55,0,0,1,0));
        cyc("no_rv1",    mi(0,1,1,0,0,0,0, 'h5555,'h1112,'h7777,0,'h56),      mo(0,1,0,0,'h1112,0,'h56,0,0,1,0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single four-bank memory port between the instruction-cache and data-cache controllers. Each controller requests ownership, runs its full write-back / line-fill burst while granted, and then releases. The arbiter muxes the owner's address, data and strobes onto the memory port. It tags outstanding reads so returned data is flagged only to the requester that issued them, and drains in-flight reads before re-granting.

## Interface
- ADDR_W, 16, memory address width
- DATA_W, 16, memory data width
- RD_LAT, 2, cycles from rd_mem asserted to DataOut_mem valid (≥1)
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-high
- req_i / req_d  input  1  I-/D-cache ownership request, held high for whole burst
- Rd_i, Wr_i / Rd_d, Wr_d  input  1 each  per-requester memory strobes
- Addr_i / Addr_d  input  ADDR_W  per-requester address
- DataIn_i / DataIn_d  input  DATA_W  per-requester write data
- gnt_i / gnt_d  output  1  ownership granted (registered, one-hot or zero)
- Addr_mem  output  ADDR_W  to memory
- DataIn_mem  output  DATA_W  to memory
- rd_mem / wr_mem  output  1  to memory
- DataOut_mem  input  DATA_W  memory read data
- DataOut  output  DATA_W  DataOut_mem passed through to both requesters
- rvalid_i / rvalid_d  output  1  DataOut is return data for that requester this cycle
- busy  output  1  state ≠ IDLE
- err  output  1  protocol violation this cycle

## Operation
- States: IDLE, GNT_I, GNT_D, DRAIN.
- IDLE: gnt both 0; any req → next state GNT_x per arbitration; gnt asserts next cycle (1-cycle req→gnt latency).
- Arbitration, simultaneous req_i & req_d: see Configuration. Single request always wins.
- GNT_x: gnt_x=1. Memory outputs = owner's Addr/DataIn/Rd/Wr. Non-owner strobes ignored, no error.
- Owner asserts Rd & Wr together: err=1, rd_mem=wr_mem=0 that cycle, state unchanged.
- Owner drops req → DRAIN, gnt deasserts next cycle. Strobes in the cycle req is low are not forwarded.
- DRAIN: lasts exactly RD_LAT cycles via down-counter. In last DRAIN cycle the next state is chosen by the IDLE arbitration rule: directly to GNT_x if any req, else IDLE.
- Strobes while no grant (IDLE/DRAIN): not forwarded. err=1 if Rd or Wr high from a requester whose gnt is low and whose req is low.
- Read tagging: each forwarded rd_mem pushes {valid=1, owner} into an RD_LAT-deep shift pipe; other cycles push {0,x}. Pipe output drives rvalid_i / rvalid_d.
- Memory outputs when not forwarding: Addr_mem=0, DataIn_mem=0, rd_mem=wr_mem=0.

## Timing
- Reset values: gnt_i=gnt_d=0, rd_mem=wr_mem=0, Addr_mem=0, DataIn_mem=0, rvalid_*=0, busy=0, err=0. Tag pipe cleared; last-grant register = I.
- Memory-port outputs are combinational from the registered state plus owner inputs: zero added latency in the grant window.
- rvalid_x is high exactly RD_LAT cycles after the corresponding rd_mem cycle, including returns landing in DRAIN.
- Reset mid-burst: next cycle all outputs at reset values. In-flight reads are discarded with no rvalid.
- Req dropped and re-raised in the same owner's DRAIN: still waits full DRAIN, then re-arbitrates.

## Configuration
- ARB_RR_EN defined: round-robin. On a tie, grant goes to the requester not granted last. Last-grant register updates on every grant, reset value I, so D wins the first tie.
- ARB_RR_EN undefined: fixed priority, D-cache always wins ties. Last-grant register is not built.

## Structure
- Shared package mem_arb_pkg: state enum, requester ID constants (REQ_I=0, REQ_D=1), tag struct {valid, owner}.
- One sub-module, rd_tag_pipe: parameterised RD_LAT-deep shift register of tags with synchronous clear on rst.

## Test plan
- req_d alone, 4 Wr then 4 Rd at 0x1230..0x1236 → gnt_d one cycle after req. Memory sees identical addresses. rvalid_d high RD_LAT cycles after each Rd, 4 pulses total, rvalid_i never.
- req_i and req_d raised same cycle, twice back-to-back → RR: D then I. Fixed: D both times. Second grant starts no sooner than RD_LAT cycles after first req drop.
- D owner drops req immediately after last Rd → DRAIN 2 cycles. rvalid_d pulses in DRAIN. gnt_i asserts the cycle after DRAIN ends.
- Owner drives Rd=Wr=1 at 0x0040 → err=1, rd_mem=wr_mem=0 that cycle, grant retained.
- rst asserted mid-fill with 2 reads outstanding → next cycle all outputs zero, no rvalid afterwards, state IDLE.
- Non-owner Wr_i=1 during GNT_D with req_i=1 → not forwarded, err=0, wr_mem follows Wr_d only.
